// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control path: opcodes, state codes,
// ALU operation codes, ALU operand selects and PC source selects.
package mips_multicycle_ctrl_pkg;

  // instr[31:26] values handled by the controller
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Encodings are visible on the debug state port, so they are fixed
  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExec    = 4'd6,
    StRwb     = 4'd7,
    StBranch  = 4'd8,
    StJump    = 4'd9,
    StAddiEx  = 4'd10,
    StAddiWb  = 4'd11,
    StIllegal = 4'd12
  } state_e;

  // alu_op, consumed as op_type by the ALU control block
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  // alu_src_b selects
  localparam logic [1:0] SRC_B_REG       = 2'b00;
  localparam logic [1:0] SRC_B_FOUR      = 2'b01;
  localparam logic [1:0] SRC_B_IMM       = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SHIFT = 2'b11;

  // pc_src selects
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // Loads and stores share the address-calculation state
  function automatic logic is_mem_op(logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and the datapath/memory.
// master: the controller; slave: the datapath side.
interface mips_multicycle_ctrl_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_src, illegal_op, state
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_src, illegal_op, state
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main controller: Moore FSM with a single state register.
// Outputs decode from state only, except the mem_ready gating of FETCH
// (ir_write/pc_write) and the memory wait states.
module mips_multicycle_ctrl
  import mips_multicycle_ctrl_pkg::*;
(
  input logic                   clk,
  input logic                   rst,
  mips_multicycle_ctrl_if.master ctrl
);

  state_e state_q, state_d;

  // State register; reset returns to FETCH even mid-access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = StFetch;
    unique case (state_q)
      StFetch:  state_d = ctrl.mem_ready ? StDecode : StFetch;
      StDecode: begin
        if (ctrl.opcode == OP_RTYPE)     state_d = StExec;
        else if (is_mem_op(ctrl.opcode)) state_d = StMemAdr;
        else if (ctrl.opcode == OP_BEQ)  state_d = StBranch;
        else if (ctrl.opcode == OP_J)    state_d = StJump;
        else if (ctrl.opcode == OP_ADDI) state_d = StAddiEx;
        else                             state_d = StIllegal;
      end
      StMemAdr:  state_d = (ctrl.opcode == OP_LW) ? StMemRd : StMemWr;
      StMemRd:   state_d = ctrl.mem_ready ? StMemWb : StMemRd;
      StMemWb:   state_d = StFetch;
      StMemWr:   state_d = ctrl.mem_ready ? StFetch : StMemWr;
      StExec:    state_d = StRwb;
      StRwb:     state_d = StFetch;
      StBranch:  state_d = StFetch;
      StJump:    state_d = StFetch;
      StAddiEx:  state_d = StAddiWb;
      StAddiWb:  state_d = StFetch;
      StIllegal: state_d = StFetch;
      // Unused codes 13-15 recover to FETCH
      default:   state_d = StFetch;
    endcase
  end

  // Output decode; anything not set in a state stays 0
  always_comb begin
    ctrl.pc_write      = 1'b0;
    ctrl.pc_write_cond = 1'b0;
    ctrl.i_or_d        = 1'b0;
    ctrl.mem_read      = 1'b0;
    ctrl.mem_write     = 1'b0;
    ctrl.ir_write      = 1'b0;
    ctrl.reg_dst       = 1'b0;
    ctrl.mem_to_reg    = 1'b0;
    ctrl.reg_write     = 1'b0;
    ctrl.alu_src_a     = 1'b0;
    ctrl.alu_src_b     = SRC_B_REG;
    ctrl.alu_op        = ALU_OP_ADD;
    ctrl.pc_src        = PC_SRC_ALU;
    ctrl.illegal_op    = 1'b0;
    unique case (state_q)
      StFetch: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRC_B_FOUR;
        // IR load and PC+4 only once the fetch completes
        ctrl.ir_write  = ctrl.mem_ready;
        ctrl.pc_write  = ctrl.mem_ready;
      end
      StDecode: begin
        ctrl.alu_src_b = SRC_B_IMM_SHIFT;
      end
      StMemAdr: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
      end
      StMemRd: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      StMemWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      StMemWr: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      StExec: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_OP_FUNCT;
      end
      StRwb: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      StBranch: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_OP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_src        = PC_SRC_ALUOUT;
      end
      StJump: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PC_SRC_JUMP;
      end
      StAddiEx: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
      end
      StAddiWb: begin
        ctrl.reg_write = 1'b1;
      end
      StIllegal: begin
        ctrl.illegal_op = 1'b1;
      end
      default: ;
    endcase
  end

  assign ctrl.state = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed vector table,
// hand-written reset/stall sequences and randomized instruction streams.
module tb_mips_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       illegal_op;
  } outs_t;

  typedef struct {
    int   st;
    logic mr;
  } step_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    int         fetch_stall;
    int         mem_stall;
    int         cycles;
  } vec_t;

  step_t steps[$];

  // Control word each state must produce, written from the state descriptions
  function automatic outs_t expect_outs(int st, logic mr);
    outs_t o = '0;
    case (st)
      0:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_write = mr; end
      1:  o.alu_src_b = 2'b11;
      2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      3:  begin o.mem_read = 1; o.i_or_d = 1; end
      4:  begin o.reg_write = 1; o.mem_to_reg = 1; end
      5:  begin o.mem_write = 1; o.i_or_d = 1; end
      6:  begin o.alu_src_a = 1; o.alu_op = 2'b10; end
      7:  begin o.reg_write = 1; o.reg_dst = 1; end
      8:  begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_write_cond = 1; o.pc_src = 2'b01; end
      9:  begin o.pc_write = 1; o.pc_src = 2'b10; end
      10: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      11: o.reg_write = 1;
      12: o.illegal_op = 1;
      default: ;
    endcase
    return o;
  endfunction

  function automatic outs_t sample_outs();
    outs_t o;
    o.pc_write      = bus.pc_write;
    o.pc_write_cond = bus.pc_write_cond;
    o.i_or_d        = bus.i_or_d;
    o.mem_read      = bus.mem_read;
    o.mem_write     = bus.mem_write;
    o.ir_write      = bus.ir_write;
    o.reg_dst       = bus.reg_dst;
    o.mem_to_reg    = bus.mem_to_reg;
    o.reg_write     = bus.reg_write;
    o.alu_src_a     = bus.alu_src_a;
    o.alu_src_b     = bus.alu_src_b;
    o.alu_op        = bus.alu_op;
    o.pc_src        = bus.pc_src;
    o.illegal_op    = bus.illegal_op;
    return o;
  endfunction

  // Cycle count of a whole instruction with mem_ready always high
  function automatic int base_cycles(logic [5:0] op);
    case (op)
      6'b000000: return 4;
      6'b100011: return 5;
      6'b101011: return 4;
      6'b000100: return 3;
      6'b000010: return 3;
      6'b001000: return 4;
      default:   return 3;
    endcase
  endfunction

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string name, input outs_t act, input outs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: outputs got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Phase sequence of one instruction: fetch, decode, then the opcode's path
  task automatic build_steps(input logic [5:0] op, input int fs, input int ms);
    steps.delete();
    for (int i = 0; i < fs; i++) steps.push_back('{0, 1'b0});
    steps.push_back('{0, 1'b1});
    steps.push_back('{1, 1'b1});
    case (op)
      6'b000000: begin steps.push_back('{6, 1'b1}); steps.push_back('{7, 1'b1}); end
      6'b100011: begin
        steps.push_back('{2, 1'b1});
        for (int i = 0; i < ms; i++) steps.push_back('{3, 1'b0});
        steps.push_back('{3, 1'b1});
        steps.push_back('{4, 1'b1});
      end
      6'b101011: begin
        steps.push_back('{2, 1'b1});
        for (int i = 0; i < ms; i++) steps.push_back('{5, 1'b0});
        steps.push_back('{5, 1'b1});
      end
      6'b000100: steps.push_back('{8, 1'b1});
      6'b000010: steps.push_back('{9, 1'b1});
      6'b001000: begin steps.push_back('{10, 1'b1}); steps.push_back('{11, 1'b1}); end
      default:   steps.push_back('{12, 1'b1});
    endcase
  endtask

  // Entered just after a rising edge with the DUT in FETCH; leaves it the same way
  task automatic run_instr(input string name, input logic [5:0] op, input int fs,
                           input int ms, input int exp_cycles);
    int    seen_busy = 0;
    int    done_at   = -1;
    int    n;
    int    st;
    build_steps(op, fs, ms);
    n = steps.size();
    bus.opcode = op;
    // One extra cycle (mem_ready low) to observe the return to FETCH
    for (int i = 0; i <= n; i++) begin
      step_t s;
      if (i < n) s = steps[i];
      else       s = '{0, 1'b0};
      bus.mem_ready = s.mr;
      @(negedge clk);
      st = int'(bus.state);
      check_int({name, " state"}, st, s.st);
      check_outs({name, " outs"}, sample_outs(), expect_outs(s.st, s.mr));
      if (st != 0) seen_busy = 1;
      else if (seen_busy != 0 && done_at < 0) done_at = i;
      @(posedge clk);
      #1;
    end
    check_int({name, " cycles"}, done_at, exp_cycles);
  endtask

  vec_t vecs[$];

  initial begin
    // Reset: FETCH decode during reset, with ir_write/pc_write following mem_ready
    rst = 1'b1;
    bus.opcode = 6'b000000;
    bus.mem_ready = 1'b0;
    #3;
    check_int("reset state", int'(bus.state), 0);
    check_outs("reset outs mr0", sample_outs(), expect_outs(0, 1'b0));
    bus.mem_ready = 1'b1;
    #1;
    check_outs("reset outs mr1", sample_outs(), expect_outs(0, 1'b1));
    @(posedge clk);
    #1;
    check_int("reset held", int'(bus.state), 0);
    rst = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check_int("after reset", int'(bus.state), 0);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a stalled load
    bus.opcode = 6'b100011;
    bus.mem_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check_int("async pre memrd", int'(bus.state), 3);
    #2 rst = 1'b1;
    #1;
    check_int("async state", int'(bus.state), 0);
    check_outs("async outs", sample_outs(), expect_outs(0, 1'b0));
    rst = 1'b0;
    @(negedge clk);
    check_int("async released state", int'(bus.state), 0);
    check_int("async mem_read", int'(bus.mem_read), 1);
    check_int("async reg_write", int'(bus.reg_write), 0);
    @(posedge clk);
    #1;

    // Directed vectors: name, opcode, fetch stall, memory stall, total cycles
    vecs.push_back('{"rtype", 6'b000000, 0, 0, 4});
    vecs.push_back('{"lw", 6'b100011, 0, 0, 5});
    vecs.push_back('{"lw_stall3", 6'b100011, 0, 3, 8});
    vecs.push_back('{"sw", 6'b101011, 0, 0, 4});
    vecs.push_back('{"sw_stall2", 6'b101011, 0, 2, 6});
    vecs.push_back('{"beq", 6'b000100, 0, 0, 3});
    vecs.push_back('{"j", 6'b000010, 0, 0, 3});
    vecs.push_back('{"addi", 6'b001000, 0, 0, 4});
    vecs.push_back('{"illegal", 6'b111111, 0, 0, 3});
    vecs.push_back('{"fetch_stall5", 6'b000000, 5, 0, 9});
    vecs.push_back('{"beq_fstall2", 6'b000100, 2, 0, 5});
    vecs.push_back('{"lui_illegal", 6'b001111, 1, 0, 4});
    foreach (vecs[i]) begin
      run_instr(vecs[i].name, vecs[i].op, vecs[i].fetch_stall, vecs[i].mem_stall,
                vecs[i].cycles);
    end

    // Randomized instruction stream
    for (int k = 0; k < 60; k++) begin
      logic [5:0] op;
      int fs;
      int ms;
      int exp;
      case ($urandom_range(0, 6))
        0: op = 6'b000000;
        1: op = 6'b100011;
        2: op = 6'b101011;
        3: op = 6'b000100;
        4: op = 6'b000010;
        5: op = 6'b001000;
        default: op = 6'($urandom);
      endcase
      fs = $urandom_range(0, 3);
      ms = $urandom_range(0, 3);
      exp = base_cycles(op) + fs;
      if (op == 6'b100011 || op == 6'b101011) exp += ms;
      run_instr($sformatf("rand%0d op%b", k, op), op, fs, ms, exp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 Parameters: none; opcode values and state encodings are fixed constants (REQ-026).
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 opcode  in  6  instr[31:26] from instruction register, sampled in DECODE and MEMADR.
REQ-005 mem_ready  in  1  memory handshake; access completes in the cycle it is high.
REQ-006 pc_write, pc_write_cond  out  1 each  PC update unconditional / branch (datapath ANDs with ALU zero).
REQ-007 i_or_d, mem_read, mem_write, ir_write  out  1 each  memory address select (0=PC), read, write, IR load.
REQ-008 reg_dst, mem_to_reg, reg_write  out  1 each  rd select, MDR write-back select, register-file write.
REQ-009 alu_src_a  out  1;  alu_src_b  out  2;  alu_op  out  2  (alu_op feeds op_type of the ALU control block).
REQ-010 pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target.
REQ-011 illegal_op  out  1  one-cycle pulse on unsupported opcode;  state  out  4  current state for debug.

Function
REQ-012 Moore FSM; outputs decoded from state only, except the mem_ready gating in REQ-014/017/018; unlisted outputs 0 in every state.
REQ-013 States/encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, ADDI_EX 10, ADDI_WB 11, ILLEGAL 12; codes 13-15 go to FETCH next cycle with all outputs 0.
REQ-014 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00; ir_write and pc_write equal mem_ready; stay while mem_ready=0, else go to DECODE.
REQ-015 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; next by opcode: 000000->EXEC, 100011/101011->MEMADR, 000100->BRANCH, 000010->JUMP, 001000->ADDI_EX, other->ILLEGAL.
REQ-016 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; opcode 100011->MEMRD, else MEMWR.
REQ-017 MEMRD: mem_read=1, i_or_d=1; hold until mem_ready=1, then MEMWB.
REQ-018 MEMWR: mem_write=1, i_or_d=1; hold until mem_ready=1, then FETCH.
REQ-019 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
REQ-020 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> RWB; RWB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
REQ-021 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01 -> FETCH.
REQ-022 JUMP: pc_write=1, pc_src=10 -> FETCH; ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDI_WB; ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
REQ-023 ILLEGAL: illegal_op=1 for exactly one cycle, no writes of any kind -> FETCH.
REQ-024 Instruction cycle counts with mem_ready tied high: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4, illegal 3.

Reset
REQ-025 rst high forces state=FETCH immediately (asynchronous), including mid-access; during and after reset outputs follow FETCH decode (mem_read=1, ir_write/pc_write=mem_ready); no other register exists.

Structure
REQ-026 Shared package holds opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI), state encodings, alu_op codes (00 add, 01 sub, 10 funct) and pc_src codes, reused by the ALU control block and datapath.
REQ-027 Single module: one state register plus combinational next-state and output decode; no sub-module.

Verification
REQ-028 rst pulse asynchronously mid-MEMRD, mem_ready=0 -> state=0 before next edge; after release FETCH, mem_read=1, no reg_write.
REQ-029 opcode=000000, mem_ready=1 -> states 0,1,6,7,0; alu_op=10 in EXEC; reg_write=1, reg_dst=1 only in RWB.
REQ-030 opcode=100011, mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, then MEMWB with reg_write=1, mem_to_reg=1; lw totals 8 cycles.
REQ-031 opcode=101011 -> MEMWR with mem_write=1, i_or_d=1, reg_write never asserted; opcode=000100 -> BRANCH alu_op=01, pc_write_cond=1, pc_src=01.
REQ-032 opcode=111111 -> ILLEGAL, illegal_op high exactly one cycle, no pc_write/reg_write/mem_write, back to FETCH.
REQ-033 FETCH with mem_ready=0 for 5 cycles -> ir_write=pc_write=0 throughout, single-cycle pulse when mem_ready rises, DECODE next.
